// File: rtl/clarvi_button_pkg.sv
// clarvi_button_pkg: register map, CONFIG bit positions and CONFIG reset value
// shared by the CLARVI button controller files.
package clarvi_button_pkg;
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_EDGE   = 2'd2;
    localparam logic [1:0] ADDR_CONFIG = 2'd3;
    localparam int CFG_RISE = 0;
    localparam int CFG_FALL = 1;
    localparam logic [1:0] CONFIG_RESET = 2'b01;
endpackage

// File: rtl/clarvi_button_debounce.sv
// clarvi_button_debounce: one input bit -- 2-flop synchroniser, tick-scheduled
// debounce counter and debounced flop.
//   clk, reset_n : clock, async active-low reset
//   tick         : shared debounce sample strobe
//   raw          : asynchronous pin
//   d            : debounced level
//   rise, fall   : one-cycle event pulses, asserted in the cycle d changes
module clarvi_button_debounce #(
    parameter int STABLE_TICKS = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic raw,
    output logic d,
    output logic rise,
    output logic fall
);
    logic [1:0] sync;
    logic [3:0] c;
    logic       s;
    logic       change;

    assign s      = sync[1];
    assign change = tick && (s != d) && (c == 4'(STABLE_TICKS - 1));
    assign rise   = change && s;
    assign fall   = change && !s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            c    <= '0;
            d    <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (tick) begin
                if (s == d || change) begin
                    c <= '0;
                end else begin
                    c <= c + 1'b1;
                end
                if (change) begin
                    d <= s;
                end
            end
        end
    end
endmodule

// File: rtl/clarvi_button_ctrl.sv
// clarvi_button_ctrl: Avalon-MM button/switch controller with debouncing,
// edge capture and a maskable level interrupt.
//   clk, reset_n : clock, async active-low reset
//   address      : word select (DATA, IRQ_MASK, EDGE_CAPTURE, CONFIG)
//   write        : write strobe; writedata: write data
//   readdata     : registered read data, valid one cycle after address
//   in_port      : raw asynchronous button inputs
//   irq          : |(EDGE_CAPTURE & IRQ_MASK)
module clarvi_button_ctrl
    import clarvi_button_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0]    pcnt;
    logic             tick;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] edge_next;
    logic [1:0]       cfg;
    logic [31:0]      rdata_next;
    logic             unused;

    assign unused = ^writedata;
    assign tick   = pcnt == PW'(TICK_DIV - 1);
    assign irq    = |(edge_cap & mask);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        clarvi_button_debounce #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_db (
            .clk    (clk),
            .reset_n(reset_n),
            .tick   (tick),
            .raw    (in_port[i]),
            .d      (d[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    // A capture event and a W1C on the same bit: set is OR'd in last so it wins.
    always_comb begin
        edge_set   = (rise & {WIDTH{cfg[CFG_RISE]}}) | (fall & {WIDTH{cfg[CFG_FALL]}});
        edge_clr   = (write && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
        edge_next  = (edge_cap & ~edge_clr) | edge_set;
        rdata_next = address == ADDR_DATA ? 32'(d) :
                     address == ADDR_MASK ? 32'(mask) :
                     address == ADDR_EDGE ? 32'(edge_cap) : 32'(cfg);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            mask     <= '0;
            edge_cap <= '0;
            cfg      <= CONFIG_RESET;
        end else begin
            readdata <= rdata_next;
            edge_cap <= edge_next;
            if (write && address == ADDR_MASK) begin
                mask <= writedata[WIDTH-1:0];
            end
            if (write && address == ADDR_CONFIG) begin
                cfg <= writedata[1:0];
            end
        end
    end
endmodule

// File: tb/tb_clarvi_button_ctrl.sv
// tb_clarvi_button_ctrl: directed self-checking bench for clarvi_button_ctrl
// with WIDTH=16, TICK_DIV=4, STABLE_TICKS=3.
module tb_clarvi_button_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [15:0] in_port = '0;
    logic        irq;
    int          cyc;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] rv;

    clarvi_button_ctrl #(
        .WIDTH(16),
        .TICK_DIV(4),
        .STABLE_TICKS(3)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .address  (address),
        .write    (write),
        .writedata(writedata),
        .readdata (readdata),
        .in_port  (in_port),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the prescaler is 0 at release, so debounce
    // updates land on edges where cyc is a multiple of 4.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        address   = a;
        writedata = v;
        write     = 1'b1;
        step();
        write     = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        address = a;
        step();
        v = readdata;
    endtask

    task automatic wait_cyc(input int target);
        for (int g = 0; g < 200 && cyc < target; g++) step();
        chk("align", cyc, target);
    endtask

    initial begin
        int found;
        int t3;
        // 1. reset
        step();
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd3, rv); chk("rst_config", rv, 32'h1);
        rd(2'd1, rv); chk("rst_mask", rv, 32'h0);
        rd(2'd2, rv); chk("rst_edge", rv, 32'h0);
        rd(2'd0, rv); chk("rst_data", rv, 32'h0);
        // 2. hold bit0 high: d updates at edge 16, readdata shows it at 17
        in_port[0] = 1'b1;
        address = 2'd0;
        found = -1;
        for (int n = 0; n < 40; n++) begin
            step();
            if (readdata == 32'h1) begin
                found = cyc;
                break;
            end
        end
        chk("data_latency", found, 32'd17);
        rd(2'd2, rv); chk("edge_rise0", rv, 32'h1);
        chk("irq_masked", {31'b0, irq}, 32'h0);
        // 3. mask, irq, W1C
        wr(2'd1, 32'h1);
        chk("irq_on_mask", {31'b0, irq}, 32'h1);
        wr(2'd2, 32'h1);
        chk("irq_off_w1c", {31'b0, irq}, 32'h0);
        rd(2'd2, rv); chk("edge_cleared", rv, 32'h0);
        rd(2'd2, rv); chk("edge_cleared2", rv, 32'h0);
        // 4. two-tick glitch on bit3 is rejected
        in_port[3] = 1'b1;
        repeat (8) step();
        in_port[3] = 1'b0;
        repeat (12) step();
        rd(2'd0, rv); chk("glitch_data", rv, 32'h1);
        rd(2'd2, rv); chk("glitch_edge", rv, 32'h0);
        chk("glitch_irq", {31'b0, irq}, 32'h0);
        // 5. falling-only capture, upper write bits ignored
        wr(2'd3, 32'hFFFF_FFFE);
        rd(2'd3, rv); chk("config_fall", rv, 32'h2);
        wr(2'd1, 32'hFFFF_0001);
        rd(2'd1, rv); chk("mask_upper", rv, 32'h1);
        in_port = 16'h0020;
        repeat (24) step();
        rd(2'd0, rv); chk("fall_data", rv, 32'h20);
        rd(2'd2, rv); chk("fall_edge", rv, 32'h1);
        chk("fall_irq", {31'b0, irq}, 32'h1);
        // 6. W1C on the exact event cycle: set wins
        wr(2'd3, 32'h3);
        wr(2'd2, 32'hFFFF);
        chk("clear_all_irq", {31'b0, irq}, 32'h0);
        in_port[0] = 1'b1;
        t3 = ((cyc + 6) / 4) * 4 + 8;
        wait_cyc(t3 - 1);
        address   = 2'd2;
        writedata = 32'h1;
        write     = 1'b1;
        step();
        write     = 1'b0;
        chk("set_wins_irq", {31'b0, irq}, 32'h1);
        rd(2'd2, rv); chk("set_wins_edge", rv, 32'h1);
        rd(2'd0, rv); chk("set_wins_data", rv, 32'h21);
        // reset mid-debounce of bit5 falling
        in_port = 16'h0001;
        repeat (5) step();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_readdata", readdata, 32'h0);
        chk("mid_rst_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        address = 2'd0;
        wait_cyc(12);
        chk("restart_before", readdata, 32'h0);
        step();
        chk("restart_after", readdata, 32'h1);
        rd(2'd2, rv); chk("restart_edge", rv, 32'h1);
        chk("restart_irq", {31'b0, irq}, 32'h0);
        rd(2'd3, rv); chk("restart_config", rv, 32'h1);
        rd(2'd1, rv); chk("restart_mask", rv, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
